// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point add/sub datapath.
// The localparams and fp_unpacked_t describe the default binary32 format.
package fp_pkg;

  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int unsigned FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;
  localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = '1;

  // Bit positions within the 4-bit flags vector {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_INX = 0;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_INV = 3;

  localparam int unsigned FP_MAX_W = 128;

  typedef enum logic {
    RNE = 1'b0,
    RTZ = 1'b1
  } rnd_mode_e;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W:0]   mant_ext;
  } fp_unpacked_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in FP_MAX_W bits
  function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int unsigned exp_w,
                                                       input int unsigned man_w);
    logic [FP_MAX_W-1:0] nan;
    nan = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      nan[man_w + i] = 1'b1;
    end
    nan[man_w - 1] = 1'b1;
    return nan;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  logic found;

  always_comb begin
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && din[WIDTH-1-i]) begin
        count = CNT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Three-stage floating-point adder/subtractor (unpack/align, add, normalise/round/pack)
// with FTZ, RNE/RTZ rounding, exception flags and a single global stall enable.
module fp_add_sub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic                   rnd_mode,
  input  logic [EXP_W+MAN_W:0]   a_fpn,
  input  logic [EXP_W+MAN_W:0]   b_fpn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned XW  = MAN_W + 3;           // mantissa + G + R before sticky
  localparam int unsigned AW  = MAN_W + 4;           // hidden, fraction, G, R, S
  localparam int unsigned SW  = MAN_W + 5;           // carry + AW
  localparam int unsigned EW  = EXP_W + 2;           // exponent with headroom and sign
  localparam int unsigned LZW = $clog2(MAN_W + 3);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAN_W + 3);
  localparam logic [XW-1:0]    EXT_ONES  = '1;
  localparam logic [W-1:0]     QNAN      = W'(fp_canon_nan(EXP_W, MAN_W));

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } opnd_t;

  typedef struct packed {
    logic             valid;
    logic             special;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flags;
    logic             sign;
    logic             zero_sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [AW-1:0]    big_m;
    logic [AW-1:0]    small_m;
    rnd_mode_e        rnd;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             special;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flags;
    logic             sign;
    logic             zero_sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
    rnd_mode_e        rnd;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     out_d, out_q;
  logic [3:0]       flags_d, flags_q;
  logic             en;

  // Stage 1 signals
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [W-2:0]     a_mag, b_mag;
  logic             a_big;
  opnd_t            ua, ub, big;
  logic [EXP_W-1:0] small_exp, diff;
  logic [MAN_W:0]   small_mant;
  logic [XW-1:0]    ext, shifted;
  logic             sticky;
  logic             spec;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;

  // Stage 3 signals
  logic [MAN_W+1:0] lzc_in;
  logic [LZW-1:0]   lzc;
  logic             carry, g, r, st, lsb, inc;
  logic [AW-1:0]    norm_m;
  logic [EW-1:0]    exp_base, exp_n, exp_r;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res;
  logic [3:0]       res_flags;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  always_comb begin : stage1_unpack_align
    a_sign = a_fpn[W-1];
    b_sign = b_fpn[W-1] ^ ~op;
    a_exp  = a_fpn[W-2 -: EXP_W];
    b_exp  = b_fpn[W-2 -: EXP_W];
    a_frac = a_fpn[MAN_W-1:0];
    b_frac = b_fpn[MAN_W-1:0];

    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    a_snan = a_nan && !a_frac[MAN_W-1];
    b_snan = b_nan && !b_frac[MAN_W-1];

    // Subnormals count as zero magnitude so FTZ also governs the swap
    a_mag = a_zero ? '0 : a_fpn[W-2:0];
    b_mag = b_zero ? '0 : b_fpn[W-2:0];
    a_big = (a_mag >= b_mag);

    ua.sign = a_sign;
    ua.exp  = a_zero ? '0 : a_exp;
    ua.mant = a_zero ? '0 : {1'b1, a_frac};
    ub.sign = b_sign;
    ub.exp  = b_zero ? '0 : b_exp;
    ub.mant = b_zero ? '0 : {1'b1, b_frac};

    big        = a_big ? ua : ub;
    small_exp  = a_big ? ub.exp : ua.exp;
    small_mant = a_big ? ub.mant : ua.mant;
    diff       = big.exp - small_exp;

    ext = {small_mant, 2'b00};
    if (diff >= ALIGN_LIM) begin
      shifted = '0;
      sticky  = |small_mant;
    end else begin
      shifted = ext >> diff;
      sticky  = |(ext & ~(EXT_ONES << diff));
    end

    spec       = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec                 = 1'b1;
      spec_res             = QNAN;
      spec_flags[FLAG_INV] = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec                 = 1'b1;
      spec_res             = QNAN;
      spec_flags[FLAG_INV] = 1'b1;
    end else if (a_inf) begin
      spec     = 1'b1;
      spec_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec     = 1'b1;
      spec_res = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end

    s1_d = s1_q;
    if (en) begin
      s1_d.valid      = in_valid;
      s1_d.special    = spec;
      s1_d.spec_res   = spec_res;
      s1_d.spec_flags = spec_flags;
      s1_d.sign       = big.sign;
      s1_d.zero_sign  = (a_sign == b_sign) ? a_sign : 1'b0;
      s1_d.sub        = (a_sign != b_sign);
      s1_d.exp        = big.exp;
      s1_d.big_m      = {big.mant, 3'b000};
      s1_d.small_m    = {shifted, sticky};
      s1_d.rnd        = rnd_mode_e'(rnd_mode);
    end
  end

  always_comb begin : stage2_add
    s2_d = s2_q;
    if (en) begin
      s2_d.valid      = s1_q.valid;
      s2_d.special    = s1_q.special;
      s2_d.spec_res   = s1_q.spec_res;
      s2_d.spec_flags = s1_q.spec_flags;
      s2_d.sign       = s1_q.sign;
      s2_d.zero_sign  = s1_q.zero_sign;
      s2_d.exp        = s1_q.exp;
      s2_d.rnd        = s1_q.rnd;
      s2_d.sum        = s1_q.sub ? ({1'b0, s1_q.big_m} - {1'b0, s1_q.small_m})
                                 : ({1'b0, s1_q.big_m} + {1'b0, s1_q.small_m});
    end
  end

  // Only hidden..G need scanning: massive cancellation only happens when R/S are zero
  assign lzc_in = s2_q.sum[AW-1:2];

  fp_lzc #(
    .WIDTH (MAN_W + 2),
    .CNT_W (LZW)
  ) u_lzc (
    .din   (lzc_in),
    .count (lzc)
  );

  always_comb begin : stage3_norm_round
    exp_base = {2'b00, s2_q.exp};
    carry    = s2_q.sum[SW-1];
    if (carry) begin
      norm_m = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n  = exp_base + EW'(1);
    end else begin
      norm_m = s2_q.sum[AW-1:0] << lzc;
      exp_n  = exp_base - EW'(lzc);
    end

    lsb = norm_m[3];
    g   = norm_m[2];
    r   = norm_m[1];
    st  = norm_m[0];
    inc = (s2_q.rnd == RNE) && g && (r || st || lsb);

    mant_r = {1'b0, norm_m[AW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (mant_r[MAN_W+1]) begin
      exp_r  = exp_n + EW'(1);
      frac_r = mant_r[MAN_W:1];
    end else begin
      exp_r  = exp_n;
      frac_r = mant_r[MAN_W-1:0];
    end

    res                 = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
    res_flags           = '0;
    res_flags[FLAG_INX] = g | r | st;
    if (s2_q.special) begin
      res       = s2_q.spec_res;
      res_flags = s2_q.spec_flags;
    end else if (s2_q.sum == '0) begin
      res       = {s2_q.zero_sign, {(W-1){1'b0}}};
      res_flags = '0;
    end else if (exp_n[EW-1] || (exp_n == '0)) begin
      res                 = {s2_q.sign, {(W-1){1'b0}}};
      res_flags           = '0;
      res_flags[FLAG_UNF] = 1'b1;
      res_flags[FLAG_INX] = 1'b1;
    end else if (exp_r >= {2'b00, EXP_ONES}) begin
      res                 = (s2_q.rnd == RNE)
                          ? {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}}
                          : {s2_q.sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
      res_flags           = '0;
      res_flags[FLAG_OVF] = 1'b1;
      res_flags[FLAG_INX] = 1'b1;
    end

    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    if (en) begin
      out_valid_d = s2_q.valid;
      if (s2_q.valid) begin
        out_d   = res;
        flags_d = res_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe: arithmetic/special vectors, backpressure, async reset.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic        rnd_mode;
  logic [31:0] a_fpn;
  logic [31:0] b_fpn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int          tx;
  int          rx;
  logic        acc;
  logic        stall_seen;
  logic [31:0] held_out;
  logic [3:0]  held_flags;
  int          stale;
  logic [31:0] bp_b   [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_exp [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000};

  always #5 clk = ~clk;

  fp_add_sub_pipe #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rnd_mode  (rnd_mode),
    .a_fpn     (a_fpn),
    .b_fpn     (b_fpn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic opv, input logic rndv,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input logic [3:0] fl);
    int unsigned cyc;
    @(negedge clk);
    op        = opv;
    rnd_mode  = rndv;
    a_fpn     = av;
    b_fpn     = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && cyc < 8) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_lat"}, cyc, 32'd3);
    check({tag, "_out"}, out, res);
    check({tag, "_flg"}, 32'(flags), 32'(fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b1;
    rnd_mode  = 1'b0;
    a_fpn     = '0;
    b_fpn     = '0;
    #2 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_1_2",     1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op("tie_even",    1'b1, 1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001);
    run_op("tie_odd",     1'b1, 1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001);
    run_op("x_minus_x",   1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000);
    run_op("inf_m_inf",   1'b0, 1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
    run_op("qnan",        1'b1, 1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    run_op("snan",        1'b1, 1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_op("ovf_rne",     1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
    run_op("ovf_rtz",     1'b1, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0101);
    run_op("one_m_inf",   1'b0, 1'b0, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000);
    run_op("negz_negz",   1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
    run_op("underflow",   1'b0, 1'b0, 32'h00800000, 32'h00C00000, 32'h80000000, 4'b0011);
    run_op("far_add",     1'b1, 1'b0, 32'h3F800000, 32'h0D800000, 32'h3F800000, 4'b0001);
    run_op("far_sub_rtz", 1'b0, 1'b1, 32'h3F800000, 32'h0D800000, 32'h3F7FFFFF, 4'b0001);
    run_op("far_sub_rne", 1'b0, 1'b0, 32'h3F800000, 32'h0D800000, 32'h3F800000, 4'b0001);
    run_op("neg_result",  1'b0, 1'b0, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000);
    run_op("ftz_sub_in",  1'b1, 1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000);

    // Streamed beats with a five-cycle consumer stall mid-stream
    tx         = 0;
    rx         = 0;
    stall_seen = 1'b0;
    held_out   = '0;
    held_flags = '0;
    for (int t = 0; t < 60 && rx < 6; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t <= 7);
      in_valid  = (tx < 6);
      op        = 1'b1;
      rnd_mode  = 1'b0;
      a_fpn     = 32'h3F800000;
      b_fpn     = bp_b[(tx < 6) ? tx : 0];
      #1;
      if (out_valid && !out_ready) begin
        check("bp_stall_rdy", 32'(in_ready), 32'd0);
        if (stall_seen) begin
          check("bp_hold_out", out, held_out);
          check("bp_hold_flg", 32'(flags), 32'(held_flags));
        end
        held_out   = out;
        held_flags = flags;
        stall_seen = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", rx), out, bp_exp[rx]);
        check($sformatf("bp_flg%0d", rx), 32'(flags), 32'd0);
        rx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) tx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_rx", 32'(rx), 32'd6);
    check("bp_tx", 32'(tx), 32'd6);
    check("bp_stalled", 32'(stall_seen), 32'd1);
    stale = 0;
    repeat (4) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    check("bp_no_dup", 32'(stale), 32'd0);

    // Asynchronous reset with two operations in flight
    @(negedge clk);
    op        = 1'b1;
    rnd_mode  = 1'b0;
    a_fpn     = 32'h3F800000;
    b_fpn     = 32'h40000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_fpn = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_out", out, 32'h0);
    check("rst2_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst2_no_stale", 32'(stale), 32'd0);
    run_op("post_rst", 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
